keypad_scanner: RTL and testbench

Scans the 4x4 button matrix by driving one column low at a time and sampling the pulled-up rows. Each key is debounced per scan. Debounced transitions are queued as key events on a valid/ready stream. It sits directly upstream of the sequencer model and supplies the key index (`row*4 + col`) that `top` currently derives combinationally.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_event_fifo.sv | 56 +++++
 rtl/keypad_scanner.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Optional feature macro used by the scanner: KEYPAD_RELEASE_EVENTS_EN.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] key_idx_t;

  typedef struct packed {
    key_idx_t key;
    logic     press;
  } key_evt_t;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    EMIT
  } scan_state_e;

  // Key index is row*4 + col, which for a 4x4 matrix is just {row, col}.
  function automatic key_idx_t key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Lowest set bit of a row mask; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small show-ahead FIFO of key events.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two and at least 2.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  key_evt_t push_evt,
  output logic     full,
  input  logic     pop,
  output logic     empty,
  output key_evt_t head
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t        mem_reg [DEPTH];
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // One register slot per entry; reset so the head reads as zero out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
        mem_reg[gi] <= push_evt;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad with per-key debounce and an
// event queue on a valid/ready stream.
// Define KEYPAD_RELEASE_EVENTS_EN to also queue key releases (evt_press = 0);
// otherwise only presses are queued and releases update key_state silently.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic [15:0] key_state,
  output logic        overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    row_meta_reg, row_sync_reg;
  scan_state_e   state_reg, state_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [1:0]    col_reg, col_next;
  logic [3:0]    col_n_reg;
  logic [15:0]   key_state_reg, key_state_next;
  logic [15:0]   flip, report;
  logic [3:0]    pending_reg, pending_next, pending_set;
  logic          overflow_reg;
  logic          push, pop, fifo_full, fifo_empty;
  key_evt_t      push_evt, head;

  // Two-flop synchronizer on the asynchronous rows; idle level is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Per-key debounce: only keys in the driven column are evaluated in SAMPLE.
  for (genvar gi = 0; gi < NUM_ROWS * NUM_COLS; gi++) begin : g_key
    logic          raw, sel, flip_k;
    logic [CW-1:0] deb_cnt_reg, deb_cnt_next;

    assign raw = ~row_sync_reg[gi / NUM_COLS];
    assign sel = (state_reg == SAMPLE) && (col_reg == 2'(gi % NUM_COLS));

    // Count disagreeing samples; flip once the count reaches DEBOUNCE_SCANS.
    always_comb begin
      deb_cnt_next = deb_cnt_reg;
      flip_k       = 1'b0;
      if (sel) begin
        if (raw == key_state_reg[gi]) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg >= CW'(DEBOUNCE_SCANS - 1)) begin
          deb_cnt_next = '0;
          flip_k       = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end
    end

    assign flip[gi] = flip_k;

    // Debounce counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_cnt_reg <= '0;
      else        deb_cnt_reg <= deb_cnt_next;
    end
  end

  assign key_state_next = key_state_reg ^ flip;

`ifdef KEYPAD_RELEASE_EVENTS_EN
  assign report = flip;
`else
  assign report = flip & key_state_next;
`endif

  // A row needs an event if its key in the current column made a reportable flip.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    assign pending_set[gi] = |report[gi*NUM_COLS +: NUM_COLS];
  end

  // Scan FSM: dwell on a column, sample it, then emit its events one per cycle.
  always_comb begin
    logic [1:0] row_sel;
    logic [3:0] remaining;
    key_idx_t   k;
    state_next   = state_reg;
    dwell_next   = dwell_reg;
    col_next     = col_reg;
    pending_next = pending_reg;
    push         = 1'b0;
    push_evt     = '0;
    row_sel      = lowest_set(pending_reg);
    remaining    = pending_reg & ~(4'b0001 << row_sel);
    k            = key_index(row_sel, col_reg);
    case (state_reg)
      DRIVE: begin
        if (dwell_reg == DW'(SCAN_DIV - 1)) begin
          dwell_next = '0;
          state_next = SAMPLE;
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
      SAMPLE: begin
        pending_next = pending_set;
        if (pending_set == 4'b0000) begin
          col_next   = col_reg + 2'd1;
          state_next = DRIVE;
        end else begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (pending_reg != 4'b0000) begin
          push           = 1'b1;
          push_evt.key   = k;
          push_evt.press = key_state_reg[k];
          pending_next   = remaining;
        end
        if (remaining == 4'b0000) begin
          col_next   = col_reg + 2'd1;
          dwell_next = '0;
          state_next = DRIVE;
        end
      end
      default: state_next = DRIVE;
    endcase
  end

  // Scanner state registers, including the registered column drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= DRIVE;
      dwell_reg     <= '0;
      col_reg       <= 2'd0;
      col_n_reg     <= 4'b1110;
      key_state_reg <= '0;
      pending_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      dwell_reg     <= dwell_next;
      col_reg       <= col_next;
      col_n_reg     <= ~(4'b0001 << col_next);
      key_state_reg <= key_state_next;
      pending_reg   <= pending_next;
    end
  end

  assign pop = !fifo_empty && evt_ready;

  keypad_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_evt(push_evt),
    .full    (fifo_full),
    .pop     (pop),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Sticky drop flag: a push into a full queue with no simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_reg <= 1'b0;
    else if (push && fifo_full && !pop) overflow_reg <= 1'b1;
  end

`ifdef KEYPAD_RELEASE_EVENTS_EN
  assign evt_press = head.press;
`else
  logic after_reset_reg;

  // Only presses are queued, so evt_press reads 1 from the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) after_reset_reg <= 1'b0;
    else        after_reset_reg <= 1'b1;
  end

  assign evt_press = head.press | after_reset_reg;
`endif

  assign col_n     = col_n_reg;
  assign evt_valid = !fifo_empty;
  assign evt_key   = head.key;
  assign key_state = key_state_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix model drives rows from the column drive; expected
// events go into a queue when stimulus is applied and are compared on handshake.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic [15:0] key_state;
  logic        overflow;

  logic [15:0] pressed = 16'h0000;
  logic [15:0] model_state = 16'h0000;
  logic        exp_ovf = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
  } ev_t;

  ev_t exp_q[$];

  typedef struct {
    logic [15:0] mask;
    logic [15:0] exp_state;
  } vec_t;

  vec_t vecs [7];

  keypad_scanner #(
    .SCAN_DIV      (8),
    .DEBOUNCE_SCANS(2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_press(evt_press),
    .key_state(key_state),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: compare each accepted event against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_evt: got key %0d press %0d expected none", evt_key, evt_press);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("evt", {evt_key, evt_press}, {e.key, e.press});
        $display("event key %0d press %0d", evt_key, evt_press);
      end
    end
  end

  // Expected events from a debounced transition: column order, then row order.
  task automatic model_events(input logic [15:0] old_m, input logic [15:0] new_m);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        int  k;
        ev_t e;
        k = r * 4 + c;
        e.key   = 4'(k);
        e.press = new_m[k];
        if (old_m[k] != new_m[k]) begin
`ifdef KEYPAD_RELEASE_EVENTS_EN
          exp_q.push_back(e);
`else
          if (new_m[k]) exp_q.push_back(e);
`endif
        end
      end
    end
  endtask

  // Return just after the edge on which column 0 starts being driven.
  task automatic wait_col0_start();
    logic [3:0] prev;
    prev = col_n;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (col_n == 4'b1110 && prev != 4'b1110) return;
      prev = col_n;
    end
    n_checks++;
    $display("FAIL col0_timeout: got no column 0 start within 400 cycles expected one");
  endtask

  task automatic apply_mask(input logic [15:0] mask);
    wait_col0_start();
    pressed = mask;
    model_events(model_state, mask);
    model_state = mask;
    repeat (3) wait_col0_start();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] col_seq [4];
    int         n;
    int         valid_cycles;
    logic [3:0] prev;

    vecs[0] = '{16'h0040, 16'h0040};
    vecs[1] = '{16'h0000, 16'h0000};
    vecs[2] = '{16'h8001, 16'h8001};
    vecs[3] = '{16'h8000, 16'h8000};
    vecs[4] = '{16'h0000, 16'h0000};
    vecs[5] = '{16'h1234, 16'h1234};
    vecs[6] = '{16'h0000, 16'h0000};
    col_seq[0] = 4'b1101;
    col_seq[1] = 4'b1011;
    col_seq[2] = 4'b0111;
    col_seq[3] = 4'b1110;

    // Reset state
    rst_n     = 1'b0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_n", 32'(col_n), 32'(4'b1110));
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_key", 32'(evt_key), 0);
    chk("rst_evt_press", 32'(evt_press), 0);
    chk("rst_key_state", 32'(key_state), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    // Column rotation with no keys: one step every SCAN_DIV+1 cycles
    wait_col0_start();
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      prev = col_n;
      while (col_n == prev && n < 50) begin
        @(posedge clk);
        #1;
        n++;
        if (evt_valid) valid_cycles++;
      end
      chk("col_interval", 32'(n), 9);
      chk("col_value", 32'(col_n), 32'(col_seq[i]));
      $display("column step %0d col_n %b after %0d cycles", i, col_n, n);
    end
    chk("idle_evt_valid", 32'(valid_cycles), 0);

    // Table-driven key patterns with the consumer always ready
    evt_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      apply_mask(vecs[i].mask);
      chk("vec_key_state", 32'(key_state), 32'(vecs[i].exp_state));
      chk("vec_overflow", 32'(overflow), 32'(exp_ovf));
      $display("vector %0d mask %h key_state %h", i, vecs[i].mask, key_state);
    end

    // Single-sample glitch on key 0, twice with an agreeing scan between
    for (int g = 0; g < 2; g++) begin
      wait_col0_start();
      pressed = 16'h0001;
      n = 0;
      while (col_n == 4'b1110 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      pressed = 16'h0000;
      wait_col0_start();
    end
    wait_col0_start();
    chk("glitch_key_state", 32'(key_state), 0);
    chk("glitch_evt_valid", 32'(evt_valid), 0);
    $display("glitch key_state %h", key_state);

    // Overflow: four presses fill the queue, a fifth is dropped
    evt_ready = 1'b0;
    apply_mask(16'h00F0);
    chk("full_evt_valid", 32'(evt_valid), 1);
    chk("full_head_key", 32'(evt_key), 4);
    chk("full_head_press", 32'(evt_press), 1);
    chk("full_overflow", 32'(overflow), 0);
    wait_col0_start();
    pressed = 16'h00F1;
    model_state = 16'h00F1;
    exp_ovf = 1'b1;
    repeat (3) wait_col0_start();
    chk("drop_overflow", 32'(overflow), 1);
    chk("drop_key_state", 32'(key_state), 32'(16'h00F1));
    chk("drop_head_key", 32'(evt_key), 4);
    evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_queue_left", 32'(exp_q.size()), 0);
    chk("drain_evt_valid", 32'(evt_valid), 0);
    apply_mask(16'h0000);
    chk("release_key_state", 32'(key_state), 0);

    // Reset in the middle of emitting two events from column 2
    evt_ready = 1'b0;
    wait_col0_start();
    pressed = 16'h0044;
    n = 0;
    while (evt_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("emit_seen_valid", 32'(evt_valid), 1);
    chk("emit_key_state", 32'(key_state), 32'(16'h0044));
    rst_n = 1'b0;
    #1;
    chk("arst_col_n", 32'(col_n), 32'(4'b1110));
    chk("arst_evt_valid", 32'(evt_valid), 0);
    chk("arst_evt_key", 32'(evt_key), 0);
    chk("arst_evt_press", 32'(evt_press), 0);
    chk("arst_key_state", 32'(key_state), 0);
    chk("arst_overflow", 32'(overflow), 0);
    $display("async reset col_n %b key_state %h overflow %0d", col_n, key_state, overflow);
    pressed = 16'h0000;
    model_state = 16'h0000;
    exp_ovf = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (evt_valid) valid_cycles++;
    end
    chk("post_rst_evt_valid", 32'(valid_cycles), 0);
    chk("post_rst_key_state", 32'(key_state), 0);

    repeat (5) @(posedge clk);
    chk("final_queue_left", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
